// File: rtl/xg_pkg.sv
// Shared types and constants for the XenonGecko memory arbiter slice.
package xg_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VID  = 2'd1,
    S_CPU  = 2'd2
  } xgarb_state_t;

  localparam logic [1:0] XG_BURST_LAST = 2'd3;
  localparam logic [3:0] XG_STARVE_MAX = 4'd15;
  localparam int         XG_ADDR_W     = 24;

  typedef struct packed {
    logic                 pending;
    logic                 wren;
    logic [XG_ADDR_W-1:0] addr;
  } xg_req_t;

endpackage

// File: rtl/xg_req_slot.sv
// One-deep request capture: holds a single burst request until its burst completes.
module xg_req_slot #(
  parameter int ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              wren_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              clear_i,
  output logic              pending_o,
  output logic              wren_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              overrun_o
);

  logic              pending_q, pending_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              occupied;

  // A slot being cleared this cycle counts as free, so a new pulse lands.
  assign occupied  = pending_q & ~clear_i;
  assign overrun_o = req_i & occupied;

  always_comb begin
    pending_d = pending_q;
    wren_d    = wren_q;
    addr_d    = addr_q;
    if (clear_i) begin
      pending_d = 1'b0;
    end
    if (req_i && !occupied) begin
      pending_d = 1'b1;
      wren_d    = wren_i;
      addr_d    = addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= '0;
    end else begin
      pending_q <= pending_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
    end
  end

  assign pending_o = pending_q;
  assign wren_o    = wren_q;
  assign addr_o    = addr_q;

endmodule

// File: rtl/xg_mem_arbiter.sv
// Arbitrates the 4-beat SDRAM burst port between video (priority) and CPU,
// with a starvation limit guaranteeing the CPU eventually gets a slot.
module xg_mem_arbiter
  import xg_pkg::*;
#(
  parameter int ADDR_W           = 24,
  parameter int DATA_W           = 16,
  parameter int CPU_STARVE_LIMIT = 2
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic              vid_wren,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [DATA_W-1:0] vid_wdata,
  output logic              vid_ready,
  output logic [1:0]        vid_offset,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_busy,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [1:0]        cpu_offset,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_busy,
  output logic              overrun,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] to_mem,
  input  logic              mem_ready,
  input  logic [1:0]        mem_offset,
  input  logic [DATA_W-1:0] from_mem
);

  localparam logic [3:0] STARVE_LIM = 4'(CPU_STARVE_LIMIT);

  xgarb_state_t      state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              overrun_q, overrun_d;

  logic              vid_pend, vid_swren, vid_ovr, vid_clr;
  logic              cpu_pend, cpu_swren, cpu_ovr, cpu_clr;
  logic [ADDR_W-1:0] vid_saddr, cpu_saddr;
  logic              beat_last;

  xg_req_slot #(.ADDR_W(ADDR_W)) u_vid_slot (
    .clk_i     (clk_sys),
    .rst_ni    (rst_n),
    .req_i     (vid_req),
    .wren_i    (vid_wren),
    .addr_i    (vid_addr),
    .clear_i   (vid_clr),
    .pending_o (vid_pend),
    .wren_o    (vid_swren),
    .addr_o    (vid_saddr),
    .overrun_o (vid_ovr)
  );

  xg_req_slot #(.ADDR_W(ADDR_W)) u_cpu_slot (
    .clk_i     (clk_sys),
    .rst_ni    (rst_n),
    .req_i     (cpu_req),
    .wren_i    (cpu_wren),
    .addr_i    (cpu_addr),
    .clear_i   (cpu_clr),
    .pending_o (cpu_pend),
    .wren_o    (cpu_swren),
    .addr_o    (cpu_saddr),
    .overrun_o (cpu_ovr)
  );

  assign beat_last = mem_ready & (mem_offset == XG_BURST_LAST);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    mem_req_d  = 1'b0;
    mem_wren_d = mem_wren_q;
    mem_addr_d = mem_addr_q;
    vid_clr    = 1'b0;
    cpu_clr    = 1'b0;
    overrun_d  = overrun_q | vid_ovr | cpu_ovr;
    case (state_q)
      S_IDLE: begin
        // Video wins unless the CPU has waited out the starvation limit.
        if (vid_pend && (!cpu_pend || (starve_q < STARVE_LIM))) begin
          state_d    = S_VID;
          mem_req_d  = 1'b1;
          mem_wren_d = vid_swren;
          mem_addr_d = vid_saddr;
        end else if (cpu_pend) begin
          state_d    = S_CPU;
          mem_req_d  = 1'b1;
          mem_wren_d = cpu_swren;
          mem_addr_d = cpu_saddr;
          starve_d   = 4'd0;
        end
      end
      S_VID: begin
        if (beat_last) begin
          vid_clr = 1'b1;
          state_d = S_IDLE;
          if (cpu_pend && (starve_q != XG_STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      S_CPU: begin
        if (beat_last) begin
          cpu_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      starve_q   <= 4'd0;
      mem_req_q  <= 1'b0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      mem_req_q  <= mem_req_d;
      mem_wren_q <= mem_wren_d;
      mem_addr_q <= mem_addr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_wren   = mem_wren_q;
  assign mem_addr   = mem_addr_q;
  assign overrun    = overrun_q;
  assign vid_ready  = mem_ready & (state_q == S_VID);
  assign cpu_ready  = mem_ready & (state_q == S_CPU);
  assign vid_offset = mem_offset;
  assign cpu_offset = mem_offset;
  assign vid_rdata  = from_mem;
  assign cpu_rdata  = from_mem;
  assign vid_busy   = vid_pend | (state_q == S_VID);
  assign cpu_busy   = cpu_pend | (state_q == S_CPU);
  assign to_mem     = (state_q == S_VID) ? vid_wdata :
                      (state_q == S_CPU) ? cpu_wdata : '0;

endmodule

// File: tb/tb_xg_mem_arbiter.sv
// Directed self-checking bench for xg_mem_arbiter; inputs change on the
// falling edge and outputs are sampled 1ns later.
module tb_xg_mem_arbiter;

  logic        clk_sys;
  logic        rst_n;
  logic        vid_req, vid_wren, cpu_req, cpu_wren;
  logic [23:0] vid_addr, cpu_addr, mem_addr;
  logic [15:0] vid_wdata, cpu_wdata, vid_rdata, cpu_rdata, to_mem, from_mem;
  logic        vid_ready, cpu_ready, vid_busy, cpu_busy, overrun;
  logic [1:0]  vid_offset, cpu_offset, mem_offset;
  logic        mem_req, mem_wren, mem_ready;

  int nCompared;
  int nMismatched;
  int w;

  xg_mem_arbiter #(.ADDR_W(24), .DATA_W(16), .CPU_STARVE_LIMIT(2)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .vid_req    (vid_req),
    .vid_wren   (vid_wren),
    .vid_addr   (vid_addr),
    .vid_wdata  (vid_wdata),
    .vid_ready  (vid_ready),
    .vid_offset (vid_offset),
    .vid_rdata  (vid_rdata),
    .vid_busy   (vid_busy),
    .cpu_req    (cpu_req),
    .cpu_wren   (cpu_wren),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_offset (cpu_offset),
    .cpu_rdata  (cpu_rdata),
    .cpu_busy   (cpu_busy),
    .overrun    (overrun),
    .mem_req    (mem_req),
    .mem_wren   (mem_wren),
    .mem_addr   (mem_addr),
    .to_mem     (to_mem),
    .mem_ready  (mem_ready),
    .mem_offset (mem_offset),
    .from_mem   (from_mem)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic applyStimulus(input logic vReq, input logic [23:0] vAddr, input logic vWren,
                               input logic cReq, input logic [23:0] cAddr, input logic cWren);
    tick();
    vid_req  = vReq;
    vid_addr = vAddr;
    vid_wren = vWren;
    cpu_req  = cReq;
    cpu_addr = cAddr;
    cpu_wren = cWren;
  endtask

  // Waits for a grant, serves its four beats, optionally re-requests video on the last beat.
  task automatic doBurst(input logic isVid, input logic [23:0] expAddr, input logic expWren,
                         input logic reloadVid, input logic [23:0] nextVidAddr,
                         output int waitCycles);
    bit seen;
    seen = 0;
    waitCycles = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      vid_req = 1'b0;
      cpu_req = 1'b0;
      #1;
      if (mem_req) seen = 1;
      else waitCycles++;
    end
    if (!seen) begin
      checkOutput("grant_timeout", mem_req, 1);
      return;
    end
    checkOutput("mem_addr", mem_addr, expAddr);
    checkOutput("mem_wren", mem_wren, expWren);
    checkOutput("grantee_busy", isVid ? vid_busy : cpu_busy, 1);
    tick();
    #1 checkOutput("mem_req_one_cycle", mem_req, 0);
    for (int b = 0; b < 4; b++) begin
      tick();
      mem_ready  = 1'b1;
      mem_offset = 2'(b);
      from_mem   = 16'(16'hA000 + b);
      vid_wdata  = 16'(16'h5000 + b);
      cpu_wdata  = 16'(16'h6000 + b);
      if (b == 3 && reloadVid) begin
        vid_req  = 1'b1;
        vid_addr = nextVidAddr;
        vid_wren = 1'b0;
      end
      #1;
      checkOutput("vid_ready", vid_ready, isVid);
      checkOutput("cpu_ready", cpu_ready, !isVid);
      checkOutput("offset", isVid ? vid_offset : cpu_offset, b);
      checkOutput("rdata", isVid ? vid_rdata : cpu_rdata, 16'hA000 + b);
      checkOutput("to_mem", to_mem, isVid ? 16'h5000 + b : 16'h6000 + b);
    end
    tick();
    mem_ready = 1'b0;
    vid_req   = 1'b0;
    #1;
    checkOutput("idle_gap", mem_req, 0);
    checkOutput("busy_after", isVid ? vid_busy : cpu_busy, isVid ? reloadVid : 1'b0);
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    vid_req = 0; vid_wren = 0; vid_addr = '0; vid_wdata = '0;
    cpu_req = 0; cpu_wren = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 0; mem_offset = '0; from_mem = '0;
    repeat (3) tick();
    #1;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wren", mem_wren, 0);
    checkOutput("rst_busy", {vid_busy, cpu_busy}, 0);
    checkOutput("rst_overrun", overrun, 0);
    tick();
    rst_n = 1'b1;

    // Lone CPU write: grant appears two cycles after the pulse.
    applyStimulus(0, 24'h0, 0, 1, 24'h010040, 1);
    doBurst(0, 24'h010040, 1, 0, 24'h0, w);
    checkOutput("lone_latency", w, 1);

    // Simultaneous pulses with video re-requesting: V, V, C, then V.
    applyStimulus(1, 24'h000100, 0, 1, 24'h020200, 0);
    doBurst(1, 24'h000100, 0, 1, 24'h000104, w);
    checkOutput("order1_latency", w, 1);
    doBurst(1, 24'h000104, 0, 1, 24'h000108, w);
    checkOutput("order2_b2b", w, 0);
    doBurst(0, 24'h020200, 0, 0, 24'h0, w);
    checkOutput("order3_cpu_b2b", w, 0);
    doBurst(1, 24'h000108, 0, 0, 24'h0, w);
    checkOutput("order4_b2b", w, 0);

    // Starve counter was cleared by the CPU grant, so video wins again.
    applyStimulus(1, 24'h000200, 0, 1, 24'h020300, 0);
    doBurst(1, 24'h000200, 0, 0, 24'h0, w);
    doBurst(0, 24'h020300, 0, 0, 24'h0, w);
    checkOutput("starve_reset_order", w, 0);
    checkOutput("no_overrun_yet", overrun, 0);

    // Second CPU pulse while pending is dropped and flags overrun.
    applyStimulus(0, 24'h0, 0, 1, 24'h030000, 1);
    applyStimulus(0, 24'h0, 0, 1, 24'h0BAD00, 0);
    doBurst(0, 24'h030000, 1, 0, 24'h0, w);
    checkOutput("overrun_set", overrun, 1);
    tick();
    #1 checkOutput("overrun_sticky", overrun, 1);
    checkOutput("dropped_not_queued", mem_req, 0);

    // Reset during beat 1 of a CPU burst.
    applyStimulus(0, 24'h0, 0, 1, 24'h040000, 1);
    applyStimulus(0, 24'h0, 0, 0, 24'h0, 0);
    tick();
    #1 checkOutput("rstburst_grant", mem_req, 1);
    tick();
    mem_ready = 1; mem_offset = 2'd0; cpu_wdata = 16'h7777;
    #1 checkOutput("rstburst_beat0", cpu_ready, 1);
    tick();
    mem_ready = 1; mem_offset = 2'd1; rst_n = 1'b0;
    #1 checkOutput("rstburst_beat1", cpu_ready, 1);
    tick();
    rst_n = 1'b1; mem_offset = 2'd2;
    #1;
    checkOutput("rstburst_ready", {vid_ready, cpu_ready}, 0);
    checkOutput("rstburst_busy", {vid_busy, cpu_busy}, 0);
    checkOutput("rstburst_mem", {mem_req, mem_wren}, 0);
    checkOutput("rstburst_addr", mem_addr, 0);
    checkOutput("rstburst_overrun", overrun, 0);
    checkOutput("rstburst_to_mem", to_mem, 0);
    tick();
    mem_offset = 2'd3;
    #1 checkOutput("rstburst_stray3", {vid_ready, cpu_ready}, 0);
    tick();
    mem_ready = 0;
    #1 checkOutput("rstburst_no_grant", mem_req, 0);

    // Stray beats while idle change nothing.
    for (int b = 0; b < 4; b++) begin
      tick();
      mem_ready = 1; mem_offset = 2'(b);
      #1;
      checkOutput("idle_stray_ready", {vid_ready, cpu_ready}, 0);
      checkOutput("idle_stray_to_mem", to_mem, 0);
    end
    tick();
    mem_ready = 0;
    applyStimulus(1, 24'h0ABCDE, 1, 0, 24'h0, 0);
    doBurst(1, 24'h0ABCDE, 1, 0, 24'h0, w);
    checkOutput("after_stray_latency", w, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/xg_mem_arbiter.md
Name: xg_mem_arbiter

Overview:
- Shares the single 4-beat-burst SDRAM port between the XenonGecko video fetcher (xgmm) and the CPU.
- Each requester issues a one-cycle request pulse. The arbiter holds that request in a one-deep slot, grants the port, and issues the burst.
- It then routes mem_ready, mem_offset and data to and from the granted requester.
- Video has fixed priority, with a starvation limit that guarantees the CPU gets a slot. Sits between xgmm/CPU bus glue and the SDRAM controller, all on clk_sys.

Parameters:
ADDR_W, 24, memory address width
DATA_W, 16, memory word width
CPU_STARVE_LIMIT, 2, consecutive video bursts allowed while a CPU request waits (1..15)

Ports:
clk_sys  in  1  system/memory clock
rst_n  in  1  synchronous, active-low reset
vid_req  in  1  video request pulse (one cycle)
vid_wren  in  1  video write enable, sampled with vid_req
vid_addr  in  ADDR_W  video burst address, sampled with vid_req
vid_wdata  in  DATA_W  video write data for current beat
vid_ready  out  1  beat strobe to video
vid_offset  out  2  beat index to video
vid_rdata  out  DATA_W  read data to video
vid_busy  out  1  video slot occupied or in service
cpu_req  in  1  CPU request pulse (one cycle)
cpu_wren  in  1  CPU write enable, sampled with cpu_req
cpu_addr  in  ADDR_W  CPU burst address, sampled with cpu_req
cpu_wdata  in  DATA_W  CPU write data for current beat
cpu_ready  out  1  beat strobe to CPU
cpu_offset  out  2  beat index to CPU
cpu_rdata  out  DATA_W  read data to CPU
cpu_busy  out  1  CPU slot occupied or in service
overrun  out  1  sticky: a request pulse arrived while that requester's slot was occupied
mem_req  out  1  burst request pulse to SDRAM controller
mem_wren  out  1  burst write enable
mem_addr  out  ADDR_W  burst address
to_mem  out  DATA_W  write data
mem_ready  in  1  beat valid
mem_offset  in  2  beat index 0..3
from_mem  in  DATA_W  read data

Behaviour:
- Reset (rst_n=0 at a clk_sys edge):
  - State goes to S_IDLE; both slots are cleared; starve counter is 0; overrun is 0.
  - mem_req=0, mem_wren=0, mem_addr=0.
  - vid_ready, cpu_ready, vid_busy and cpu_busy are 0.
  - Reset mid-burst abandons the burst with no completion signalled. The SDRAM controller shares this reset.
- Slot capture:
  - A req pulse with its slot empty latches addr and wren and sets pending.
  - A pulse with the slot occupied is dropped and sets overrun, which stays set until reset.
  - A pulse in the same cycle that slot's burst completes is accepted, because the slot frees that cycle.
- States:
  - S_IDLE: if only one slot is pending, grant it. If both are pending, grant CPU when starve_cnt >= CPU_STARVE_LIMIT, otherwise video. On grant: mem_req<=1 for exactly one cycle; mem_addr and mem_wren come from the slot; go to S_VID or S_CPU.
  - S_VID / S_CPU: mem_req<=0. Burst ends on mem_ready & mem_offset==3. At that point the granted slot clears and state returns to S_IDLE.
- Starve counter:
  - A video burst end while the CPU slot is pending increments starve_cnt, saturating at 15.
  - A CPU grant clears it.
- Latency: with the arbiter idle, mem_req is high exactly 2 cycles after the req pulse (slot load, then grant). Back-to-back bursts have 1 idle cycle between the final beat and the next mem_req.
- Routing (combinational):
  - vid_ready = mem_ready & (state==S_VID); cpu_ready = mem_ready & (state==S_CPU).
  - vid_offset, cpu_offset = mem_offset; vid_rdata, cpu_rdata = from_mem.
  - to_mem = granted requester's wdata; 0 in S_IDLE.
- mem_ready in S_IDLE is ignored.
- busy = slot pending OR that requester is in service.
- mem_addr and mem_wren hold their value until the next grant.

Decomposition:
- Shared package xg_pkg holds:
  - enum xgarb_state_t {S_IDLE, S_VID, S_CPU};
  - the constant XG_BURST_LAST = 2'd3;
  - a struct xg_req_t {pending, wren, addr}.
- One natural sub-module, xg_req_slot: the one-deep request capture, instantiated twice. It takes req, wren, addr and a clear input, and outputs pending, wren, addr and an overrun pulse.

Test Plan:
- Reset-to-idle: lone cpu_req pulse, write, addr 0x010040 -> mem_req high 2 cycles later with mem_wren=1 and mem_addr=0x010040. cpu_ready strobes on beats 0..3; to_mem tracks cpu_wdata. cpu_busy falls the cycle after offset 3.
- Simultaneous vid_req and cpu_req pulses -> video served first, CPU second. With CPU_STARVE_LIMIT=2 and video re-requesting on each completion, the order is V, V, C; starve_cnt then returns to 0.
- Second cpu_req pulse while the CPU slot is pending -> request dropped, overrun=1 and stays set. The original address is still the one issued.
- vid_req pulse in the same cycle as the video burst's offset-3 beat -> accepted; the next mem_req follows after one idle cycle.
- rst_n low during beat 1 of a CPU burst -> the next cycle shows all outputs at their reset values. Subsequent mem_ready pulses produce no cpu_ready or vid_ready.
- Stray mem_ready/offset beats in S_IDLE -> no ready strobes and no state change.
